multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multicycle fetch/decode/control stage directly upstream of the 8x16 register file.
- Fetches 16-bit instructions over a req/ack instruction-memory handshake and holds them in an instruction register (IR).
- Drives the register-file read/write indices and the write-enable strobe.
- Sequences ALU, immediate-load, branch and jump instructions through a state machine; keeps the PC.

Parameters:
- DATA_W, 16, instruction/data width.
- ADDR_W, 16, PC/instruction-address width.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge, 0 = reset.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  DATA_W  fetched instruction.
- rs1_data  in  DATA_W  register-file ReadData1, used for the branch zero test.
- ReadReg1  out  3  register-file read index 1.
- ReadReg2  out  3  register-file read index 2.
- WriteReg  out  3  register-file write index.
- reg_write  out  1  register-file write enable, one-cycle pulse.
- wb_sel  out  1  write-data select: 0 = ALU result, 1 = imm_out.
- alu_op  out  3  ALU function (IR[14:12]).
- imm_out  out  DATA_W  zero-extended imm9.
- halted  out  1  high while in HALT.

Behaviour:
- Instruction formats (IR):
  - R-type, op 0000-0111: rd = [11:9], rs1 = [8:6], rs2 = [5:3], [2:0] ignored.
  - LOADI, op 1000: rd = [11:9], imm9 = [8:0], zero-extended.
  - BEQZ, op 1001: rs = [11:9], off9 = [8:0], signed.
  - JMP, op 1010: off12 = [11:0], signed.
  - HALT, op 1111.
  - Ops 1011-1110 are reserved and execute as NOP.
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH:
  - imem_req = 1 and imem_addr = PC.
  - On imem_ack: IR <= imem_rdata, PC <= PC+1 (wraps 16'hFFFF -> 16'h0000), go to DECODE.
  - Without ack: stay in FETCH, req held.
  - imem_ack in any other state is ignored.
- DECODE:
  - R-type -> EXECUTE.
  - LOADI -> WRITEBACK.
  - BEQZ -> EXECUTE.
  - JMP: PC <= PC + sext(off12), then FETCH.
  - HALT -> HALT.
  - Reserved -> FETCH.
- EXECUTE:
  - R-type -> WRITEBACK.
  - BEQZ: if rs1_data == 0, PC <= PC + sext(off9); then FETCH.
- WRITEBACK:
  - reg_write = 1 for exactly this cycle, then FETCH.
  - wb_sel = 1 for LOADI, 0 for R-type.
- HALT: absorbing; halted = 1; imem_req = 0; exits only via reset.
- Register indices are driven combinationally from IR in every state:
  - ReadReg1 = IR[11:9] for BEQZ, else IR[8:6].
  - ReadReg2 = IR[5:3].
  - WriteReg = IR[11:9].
- Branch/jump offsets are relative to the already-incremented PC; the sum wraps modulo 2^16.
- R0 is an ordinary writable register; no special casing.
- Latency in cycles, excluding fetch wait cycles: R-type 4, LOADI 3, BEQZ 3, JMP 2, NOP 2.
- Reset values (rst = 0 at a clk edge):
  - State = FETCH, PC = RESET_PC, IR = 0.
  - imem_req = 0, reg_write = 0, halted = 0, alu_op = 0, wb_sel = 0, imm_out = 0.
  - ReadReg1/ReadReg2/WriteReg = 0.
  - imem_req asserts on the first cycle after reset releases.
- Reset mid-operation aborts the instruction with no write pulse; it overrides any simultaneous ack.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants (OP_LOADI, OP_BEQZ, OP_JMP, OP_HALT).
  - State enum.
  - Field bit-position constants.
  - DATA_W/ADDR_W defaults.
- One combinational sub-module, instr_decode, maps IR to:
  - Register indices.
  - alu_op, wb_sel, imm_out.
  - Instruction-class flags (is_rtype, is_loadi, is_beqz, is_jmp, is_halt, is_nop).
- PC and state registers stay in multicycle_controller.

Test Plan:
1. Reset then R-type: rst low 2 cycles, release; ack instr 16'h0A98 after a 3-cycle ack delay.
   - imem_addr = 0, req held 3 cycles then acked.
   - Required: ReadReg1 = 2, ReadReg2 = 3, WriteReg = 5, alu_op = 0; single reg_write pulse in WRITEBACK with wb_sel = 0; PC = 1.
2. LOADI: instr 16'h83FF.
   - Required: WriteReg = 1, imm_out = 16'h01FF, wb_sel = 1; reg_write pulses on the 3rd cycle after ack; no EXECUTE.
3. BEQZ with PC = 16'h0010 at fetch, instr 16'h91FC (rs = 0, off = -4).
   - rs1_data = 0: next imem_addr = 16'h000D.
   - rs1_data = 7: next imem_addr = 16'h0011.
   - Required in both cases: reg_write never asserted.
4. JMP wrap: PC = 16'hFFFF at fetch, instr 16'hA002.
   - Required: PC increments to 0, next fetch at 16'h0002.
5. HALT and reserved op:
   - Instr 16'hB000: next fetch after DECODE with no write.
   - Instr 16'hF000: halted = 1, imem_req stays 0 for 20 cycles with imem_ack toggling.
   - Required: rst returns to FETCH at RESET_PC.
6. Reset mid-instruction: assert rst during WRITEBACK of an R-type.
   - Required: reg_write = 0 that cycle; all outputs at reset values; refetch from 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, states and instruction field positions
package cpu_pkg;

   localparam int CPU_DATA_W = 16;
   localparam int CPU_ADDR_W = 16;

   localparam logic [3:0] OP_LOADI = 4'b1000;
   localparam logic [3:0] OP_BEQZ  = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1010;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam int OP_HI    = 15;
   localparam int OP_LO    = 12;
   localparam int ALU_HI   = 14;
   localparam int ALU_LO   = 12;
   localparam int RD_HI    = 11;
   localparam int RD_LO    = 9;
   localparam int RS1_HI   = 8;
   localparam int RS1_LO   = 6;
   localparam int RS2_HI   = 5;
   localparam int RS2_LO   = 3;
   localparam int IMM9_HI  = 8;
   localparam int OFF12_HI = 11;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction-memory req/ack fetch bus
interface multicycle_controller_if
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_ADDR_W
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/multicycle_controller_decode.sv
// rtl/multicycle_controller_decode.sv - combinational IR field and class decode
module instr_decode
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W
) (
   input  logic [DATA_W-1:0] i_ir,
   output logic [2:0]        o_read_reg1,
   output logic [2:0]        o_read_reg2,
   output logic [2:0]        o_write_reg,
   output logic [2:0]        o_alu_op,
   output logic              o_wb_sel,
   output logic [DATA_W-1:0] o_imm_out,
   output logic              o_is_rtype,
   output logic              o_is_loadi,
   output logic              o_is_beqz,
   output logic              o_is_jmp,
   output logic              o_is_halt,
   output logic              o_is_nop
);
   logic [3:0] w_op;

   // Opcode classes; anything with the top bit set that is not a named op is a NOP
   always_comb begin
      w_op       = i_ir[OP_HI:OP_LO];
      o_is_rtype = ~w_op[3];
      o_is_loadi = (w_op == OP_LOADI);
      o_is_beqz  = (w_op == OP_BEQZ);
      o_is_jmp   = (w_op == OP_JMP);
      o_is_halt  = (w_op == OP_HALT);
      o_is_nop   = w_op[3] & ~(o_is_loadi | o_is_beqz | o_is_jmp | o_is_halt);
   end

   // Register indices and datapath controls follow the IR in every state
   always_comb begin
      o_read_reg1 = o_is_beqz ? i_ir[RD_HI:RD_LO] : i_ir[RS1_HI:RS1_LO];
      o_read_reg2 = i_ir[RS2_HI:RS2_LO];
      o_write_reg = i_ir[RD_HI:RD_LO];
      o_alu_op    = i_ir[ALU_HI:ALU_LO];
      o_wb_sel    = o_is_loadi;
      o_imm_out   = {{(DATA_W-IMM9_HI-1){1'b0}}, i_ir[IMM9_HI:0]};
   end
endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle fetch/decode/control stage with PC
module multicycle_controller
   import cpu_pkg::*;
#(
   parameter int              DATA_W   = CPU_DATA_W,
   parameter int              ADDR_W   = CPU_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   multicycle_controller_if.master bus,
   input  logic [DATA_W-1:0]   rs1_data,
   output logic [2:0]          ReadReg1,
   output logic [2:0]          ReadReg2,
   output logic [2:0]          WriteReg,
   output logic                reg_write,
   output logic                wb_sel,
   output logic [2:0]          alu_op,
   output logic [DATA_W-1:0]   imm_out,
   output logic                halted
);
   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [DATA_W-1:0] r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic              r_req;
   logic              r_reg_write;
   logic              r_halted;

   logic              w_is_rtype;
   logic              w_is_loadi;
   logic              w_is_beqz;
   logic              w_is_jmp;
   logic              w_is_halt;
   logic              w_is_nop;
   logic [ADDR_W-1:0] w_off9;
   logic [ADDR_W-1:0] w_off12;

   instr_decode #(.DATA_W(DATA_W)) u_decode (
      .i_ir        (r_ir),
      .o_read_reg1 (ReadReg1),
      .o_read_reg2 (ReadReg2),
      .o_write_reg (WriteReg),
      .o_alu_op    (alu_op),
      .o_wb_sel    (wb_sel),
      .o_imm_out   (imm_out),
      .o_is_rtype  (w_is_rtype),
      .o_is_loadi  (w_is_loadi),
      .o_is_beqz   (w_is_beqz),
      .o_is_jmp    (w_is_jmp),
      .o_is_halt   (w_is_halt),
      .o_is_nop    (w_is_nop)
   );

   // Sign-extended branch/jump offsets, added to the already-incremented PC
   always_comb begin
      w_off9  = {{(ADDR_W-IMM9_HI-1){r_ir[IMM9_HI]}}, r_ir[IMM9_HI:0]};
      w_off12 = {{(ADDR_W-OFF12_HI-1){r_ir[OFF12_HI]}}, r_ir[OFF12_HI:0]};
   end

   assign bus.imem_req  = r_req;
   assign bus.imem_addr = r_pc;
   assign reg_write     = r_reg_write;
   assign halted        = r_halted;

   // Control FSM: req, write strobe and halt flag are set on the transition into their state
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_PC;
         r_ir        <= '0;
         r_req       <= 1'b0;
         r_reg_write <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_reg_write <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (!r_req) begin
                  // Only reachable straight after reset: raise req, do not accept ack yet
                  r_req <= 1'b1;
               end else if (bus.imem_ack) begin
                  r_ir    <= bus.imem_rdata;
                  r_pc    <= r_pc + PC_ONE;
                  r_req   <= 1'b0;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_is_halt) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else if (w_is_jmp) begin
                  r_pc    <= r_pc + w_off12;
                  r_req   <= 1'b1;
                  r_state <= S_FETCH;
               end else if (w_is_loadi) begin
                  r_reg_write <= 1'b1;
                  r_state     <= S_WRITEBACK;
               end else if (w_is_nop) begin
                  r_req   <= 1'b1;
                  r_state <= S_FETCH;
               end else begin
                  r_state <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               if (w_is_rtype) begin
                  r_reg_write <= 1'b1;
                  r_state     <= S_WRITEBACK;
               end else begin
                  if (w_is_beqz && (rs1_data == '0)) begin
                     r_pc <= r_pc + w_off9;
                  end
                  r_req   <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_WRITEBACK: begin
               r_req   <= 1'b1;
               r_state <= S_FETCH;
            end
            S_HALT: begin
               r_req    <= 1'b0;
               r_halted <= 1'b1;
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= S_FETCH;
            end
         endcase
      end
   end
endmodule
